// File: rtl/fillbox_burst_gen_if.sv
// Burst command / write-response channel between the fill generator and the AXI write side.
interface fillbox_burst_gen_if #(
    parameter int unsigned ADDR_W = 28
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic [3:0]        cmd_strb;
    logic              resp_valid;
    logic              resp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_strb,
        input  cmd_ready, resp_valid, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_strb,
        output cmd_ready, resp_valid, resp_err
    );
endinterface

// File: rtl/fillbox_burst_gen.sv
// Rectangle-fill burst generator: walks width x height 16-bit pixels, emits aligned AXI bursts.
// Optional FILLBOX_ABORT_EN adds the abort input and aborted status output.
module fillbox_burst_gen #(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned DIM_W     = 10,
    parameter int unsigned STRIDE_W  = 16,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   vram,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [DIM_W-1:0]    width,
    input  logic [DIM_W-1:0]    height,
    input  logic                start,
`ifdef FILLBOX_ABORT_EN
    input  logic                abort,
    output logic                aborted,
`endif
    output logic                busy,
    output logic                done,
    output logic                err,
    fillbox_burst_gen_if.master bus
);

    localparam int unsigned OutstW  = $clog2(MAX_OUTST + 1);
    localparam int unsigned BeatLog = $clog2(MAX_BEATS);

    typedef enum logic [2:0] {StIdle, StCalc, StIssue, StDrain, StFin} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [DIM_W-1:0]    width_q, width_d;
    logic [DIM_W-1:0]    x_off_q, x_off_d;
    logic [DIM_W-1:0]    px_left_q, px_left_d;
    logic [DIM_W-1:0]    rows_left_q, rows_left_d;
    logic [DIM_W-1:0]    px_q, px_d;
    logic [OutstW-1:0]   outst_q, outst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [3:0]          strb_q, strb_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   cur;
    logic [DIM_W-1:0]    px_left_new, rows_left_new;
    logic [31:0]         beats;
    logic                hs, resp_ok, abort_req;

`ifdef FILLBOX_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign cur           = row_base_q + ADDR_W'({x_off_q, 1'b0});
    assign hs            = (state_q == StIssue) && bus.cmd_ready;
    assign resp_ok       = bus.resp_valid && (outst_q != '0);
    assign px_left_new   = px_left_q - px_q;
    assign rows_left_new = rows_left_q - DIM_W'(1);

    // Largest burst with natural alignment that still fits the pixels left; bit0 never matters.
    always_comb begin
        beats = 32'd1;
        for (int i = 0; i <= int'(BeatLog); i++) begin
            if (((cur & ADDR_W'((32'd4 << i) - 32'd2)) == '0) &&
                ((32'd2 << i) <= 32'(px_left_q))) begin
                beats = 32'd1 << i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_base_d  = row_base_q;
        stride_d    = stride_q;
        width_d     = width_q;
        x_off_d     = x_off_q;
        px_left_d   = px_left_q;
        rows_left_d = rows_left_q;
        px_d        = px_q;
        addr_d      = addr_q;
        len_d       = len_q;
        strb_d      = strb_q;
        err_d       = err_q;
        outst_d     = outst_q;

        unique case ({hs, resp_ok})
            2'b10:   outst_d = outst_q + OutstW'(1);
            2'b01:   outst_d = outst_q - OutstW'(1);
            default: outst_d = outst_q;
        endcase
        if (resp_ok && bus.resp_err) err_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    stride_d    = stride;
                    width_d     = width;
                    row_base_d  = vram & ~ADDR_W'(1);
                    x_off_d     = '0;
                    px_left_d   = width;
                    rows_left_d = height;
                    err_d       = 1'b0;
                    state_d     = ((width == '0) || (height == '0)) ? StFin : StCalc;
                end
            end
            StCalc: begin
                if (abort_req) begin
                    state_d = StDrain;
                end else if (outst_q != OutstW'(MAX_OUTST)) begin
                    addr_d  = {cur[ADDR_W-1:2], 2'b00};
                    len_d   = 8'd0;
                    px_d    = DIM_W'(1);
                    if (cur[1]) begin
                        strb_d = 4'b1100;
                    end else if (px_left_q == DIM_W'(1)) begin
                        strb_d = 4'b0011;
                    end else begin
                        strb_d = 4'b1111;
                        len_d  = 8'(beats - 32'd1);
                        px_d   = DIM_W'(beats << 1);
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (abort_req) begin
                    state_d = StDrain;
                end else if (hs) begin
                    x_off_d   = x_off_q + px_q;
                    px_left_d = px_left_new;
                    state_d   = StCalc;
                    if (px_left_new == '0) begin
                        rows_left_d = rows_left_new;
                        if (rows_left_new == '0) begin
                            state_d = StDrain;
                        end else begin
                            row_base_d = row_base_q + ADDR_W'(stride_q);
                            x_off_d    = '0;
                            px_left_d  = width_q;
                        end
                    end
                end
            end
            StDrain: if (outst_q == '0) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            row_base_q  <= '0;
            stride_q    <= '0;
            width_q     <= '0;
            x_off_q     <= '0;
            px_left_q   <= '0;
            rows_left_q <= '0;
            px_q        <= '0;
            outst_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            strb_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_base_q  <= row_base_d;
            stride_q    <= stride_d;
            width_q     <= width_d;
            x_off_q     <= x_off_d;
            px_left_q   <= px_left_d;
            rows_left_q <= rows_left_d;
            px_q        <= px_d;
            outst_q     <= outst_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            strb_q      <= strb_d;
            err_q       <= err_d;
        end
    end

`ifdef FILLBOX_ABORT_EN
    logic abort_seen_q, aborted_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            abort_seen_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            abort_seen_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            if (((state_q == StCalc) || (state_q == StIssue)) && abort) abort_seen_q <= 1'b1;
            if ((state_q == StDrain) && (state_d == StFin)) aborted_q <= abort_seen_q;
        end
    end

    assign aborted = aborted_q;
`endif

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StFin);
    assign err           = err_q;
    assign bus.cmd_valid = (state_q == StIssue);
    assign bus.cmd_addr  = addr_q;
    assign bus.cmd_len   = len_q;
    assign bus.cmd_strb  = strb_q;

endmodule
